// File: rtl/uart_emitter_if.sv
// Byte-in / serial-out handshake bundle for uart_emitter; the CPU side is master.
// The serial line rides along so a single bus carries everything the console path needs.
interface uart_emitter_if;
    logic [7:0] i_data;
    logic       i_valid;
    logic       o_ready;
    logic       o_uart_tx;

    modport master (output i_data, output i_valid, input o_ready, input o_uart_tx);
    modport slave  (input i_data, input i_valid, output o_ready, output o_uart_tx);
endinterface

// File: rtl/uart_emitter.sv
// 8N1 transmit-only UART; start bit on the accept edge, frame lasts 10*D cycles, all outputs registered.
// o_ready low for the whole frame; requests while busy are dropped, not queued.
module uart_emitter #(
    parameter int clk_freq_hz = 10000000,
    parameter int baud_rate   = 1000000
) (
    input  logic           clk,
    input  logic           resetn,
    uart_emitter_if.slave  bus
);
    localparam int D  = clk_freq_hz / baud_rate;
    localparam int BW = (D > 1) ? $clog2(D) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(D - 1);

    generate
        if (D < 2) begin : g_bad_divisor
            $error("uart_emitter: clk_freq_hz / baud_rate must be at least 2");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          rdy_q, rdy_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    // bit_q is the frame index currently on the line: 0 start, 1..8 data, 9 stop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                if (bus.i_valid && rdy_q) begin
                    shift_d = bus.i_data;
                    state_d = SEND;
                    rdy_d   = 1'b0;
                    tx_d    = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            SEND: begin
                if (baud_q == BAUD_MAX) begin
                    baud_d = '0;
                    if (bit_q == 4'd9) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        tx_d    = 1'b1;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            tx_d = 1'b1;
                        end else begin
                            tx_d    = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                        end
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.o_ready   = rdy_q;
    assign bus.o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_emitter.sv
// Directed bench for uart_emitter: default divisor (D=10) plus a 12 MHz / 3 Mbaud instance (D=4).
// Frames are sampled mid-bit and compared against {stop, data, start} built from the sent byte.
module tb_uart_emitter;
    logic clk;
    logic resetn;

    uart_emitter_if bus0 ();
    uart_emitter_if bus1 ();

    uart_emitter #(.clk_freq_hz(10000000), .baud_rate(1000000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0.slave)
    );

    uart_emitter #(.clk_freq_hz(12000000), .baud_rate(3000000)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1.slave)
    );

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int sel, input logic [7:0] d, input logic v);
        if (sel == 0) begin
            bus0.i_data  = d;
            bus0.i_valid = v;
        end else begin
            bus1.i_data  = d;
            bus1.i_valid = v;
        end
    endtask

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? bus0.o_uart_tx : bus1.o_uart_tx;
    endfunction

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? bus0.o_ready : bus1.o_ready;
    endfunction

    // Sends byte b; ign>0 pulses a competing request at edge k+ign; hold keeps i_valid high with nxt.
    task automatic run_frame(input int sel, input string tag, input logic [7:0] b,
                             input int ign, input bit hold, input logic [7:0] nxt);
        int         dd;
        int         bad;
        logic [9:0] bits;
        dd = (sel == 0) ? 10 : 4;
        drv(sel, b, 1'b1);
        tick();
        check_val({tag, "_start_tx"}, 32'(get_tx(sel)), 32'd0);
        check_val({tag, "_start_rdy"}, 32'(get_rdy(sel)), 32'd0);
        if (hold) drv(sel, nxt, 1'b1);
        else      drv(sel, b, 1'b0);
        bits = '0;
        bad  = 0;
        for (int m = 0; m < 10 * dd; m++) begin
            if (m > 0) tick();
            if (get_rdy(sel) !== 1'b0) bad++;
            if (m % dd == dd / 2) bits[m / dd] = get_tx(sel);
            if (ign > 0 && m == ign - 1) drv(sel, 8'h42, 1'b1);
            if (ign > 0 && m == ign)     drv(sel, 8'h42, 1'b0);
        end
        check_val({tag, "_busy_gaps"}, 32'(bad), 32'd0);
        check_val({tag, "_frame"}, 32'(bits), 32'({1'b1, b, 1'b0}));
        tick();
        check_val({tag, "_end_rdy"}, 32'(get_rdy(sel)), 32'd1);
        check_val({tag, "_end_tx"}, 32'(get_tx(sel)), 32'd1);
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus0.o_uart_tx !== 1'b1 || bus0.o_ready !== 1'b1) bad++;
            if (bus1.o_uart_tx !== 1'b1 || bus1.o_ready !== 1'b1) bad++;
        end
        check_val(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        drv(0, 8'h00, 1'b0);
        drv(1, 8'h00, 1'b0);

        // reset held for 3 cycles, then released away from the edge
        tick();
        check_val("rst_tx", 32'(bus0.o_uart_tx), 32'd1);
        check_val("rst_rdy", 32'(bus0.o_ready), 32'd1);
        tick();
        tick();
        resetn = 1'b1;
        check_val("rst_rel_tx", 32'(bus0.o_uart_tx), 32'd1);
        check_val("rst_rel_rdy4", 32'(bus1.o_ready), 32'd1);
        idle_check("idle_50", 50);

        run_frame(0, "b55", 8'h55, 0, 1'b0, 8'h00);
        run_frame(0, "bA3", 8'hA3, 0, 1'b0, 8'h00);
        run_frame(0, "b00", 8'h00, 0, 1'b0, 8'h00);
        run_frame(0, "bFF", 8'hFF, 0, 1'b0, 8'h00);

        // competing request mid-frame must vanish
        run_frame(0, "b41_ign", 8'h41, 30, 1'b0, 8'h00);
        idle_check("no_second_frame", 30);

        // back-to-back: i_valid held high, second start bit at k+101
        run_frame(0, "bH", 8'h48, 0, 1'b1, 8'h69);
        run_frame(0, "bi", 8'h69, 0, 1'b0, 8'h00);
        idle_check("idle_after_b2b", 5);

        // asynchronous reset between edges k+36 and k+37
        drv(0, 8'hC3, 1'b1);
        tick();
        drv(0, 8'hC3, 1'b0);
        check_val("abort_started", 32'(bus0.o_ready), 32'd0);
        for (int i = 0; i < 36; i++) tick();
        #3;
        resetn = 1'b0;
        #1;
        check_val("abort_tx", 32'(bus0.o_uart_tx), 32'd1);
        check_val("abort_rdy", 32'(bus0.o_ready), 32'd1);
        tick();
        tick();
        resetn = 1'b1;
        idle_check("idle_after_abort", 3);
        run_frame(0, "b5A", 8'h5A, 0, 1'b0, 8'h00);

        // D=4 variant
        run_frame(1, "d4_3C", 8'h3C, 0, 1'b0, 8'h00);
        run_frame(1, "d4_81", 8'h81, 0, 1'b0, 8'h00);
        idle_check("idle_end", 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
